n1_excpt_ctrl: RTL

N1_EXCPT_CTRL -- requirements
Module: N1_excpt_ctrl

---
 rtl/n1_excpt_ctrl_if.sv | 49 ++++
 rtl/n1_excpt_ctrl.sv | 130 +++++++++++++
 2 files changed

// File: rtl/n1_excpt_ctrl_if.sv
// Exception/interrupt controller signal bundle: slave = controller, master = pipeline/fetch side.
// Port names keep the block's source-to-sink prefixes so they trace back to the surrounding pipeline.
interface n1_excpt_ctrl_if #(
  parameter int IRQ_CNT  = 16,
  parameter int TC_WIDTH = 16
);
  localparam int VEC_W = (IRQ_CNT > 1) ? $clog2(IRQ_CNT) : 1;

  logic [IRQ_CNT-1:0]  irq_req_i;
  logic                ir2excpt_irq_mask_we_i;
  logic [IRQ_CNT-1:0]  ir2excpt_irq_mask_i;
  logic                ir2excpt_excpt_en_i;
  logic                ir2excpt_excpt_dis_i;
  logic                ir2excpt_irq_en_i;
  logic                ir2excpt_irq_dis_i;
  logic                fc2excpt_excpt_clr_i;
  logic                fc2excpt_irq_ack_i;
  logic                fc2excpt_buserr_i;
  logic                sagu2excpt_rsof_i;
  logic                prs2excpt_rsuf_i;
  logic                sagu2excpt_psof_i;
  logic                prs2excpt_psuf_i;
  logic                excpt2fc_excpt_o;
  logic                excpt2fc_irq_o;
  logic [TC_WIDTH-1:0] excpt2prs_tc_o;
  logic [VEC_W-1:0]    excpt2fc_irq_vec_o;
  logic [1:0]          prb_excpt_o;
  logic                prb_excpt_en_o;
  logic                prb_irq_en_o;
  logic [IRQ_CNT-1:0]  prb_irq_pend_o;

  modport master (
    output irq_req_i, ir2excpt_irq_mask_we_i, ir2excpt_irq_mask_i,
           ir2excpt_excpt_en_i, ir2excpt_excpt_dis_i, ir2excpt_irq_en_i, ir2excpt_irq_dis_i,
           fc2excpt_excpt_clr_i, fc2excpt_irq_ack_i, fc2excpt_buserr_i, sagu2excpt_rsof_i,
           prs2excpt_rsuf_i, sagu2excpt_psof_i, prs2excpt_psuf_i,
    input  excpt2fc_excpt_o, excpt2fc_irq_o, excpt2prs_tc_o, excpt2fc_irq_vec_o,
           prb_excpt_o, prb_excpt_en_o, prb_irq_en_o, prb_irq_pend_o
  );

  modport slave (
    input  irq_req_i, ir2excpt_irq_mask_we_i, ir2excpt_irq_mask_i,
           ir2excpt_excpt_en_i, ir2excpt_excpt_dis_i, ir2excpt_irq_en_i, ir2excpt_irq_dis_i,
           fc2excpt_excpt_clr_i, fc2excpt_irq_ack_i, fc2excpt_buserr_i, sagu2excpt_rsof_i,
           prs2excpt_rsuf_i, sagu2excpt_psof_i, prs2excpt_psuf_i,
    output excpt2fc_excpt_o, excpt2fc_irq_o, excpt2prs_tc_o, excpt2fc_irq_vec_o,
           prb_excpt_o, prb_excpt_en_o, prb_irq_en_o, prb_irq_pend_o
  );
endinterface

// File: rtl/n1_excpt_ctrl.sv
// Exception FSM + masked priority interrupt selector; exception pends 1 cycle after a source, irq 1 cycle
// (level) or 2 cycles (edge, N1_EXCPT_IRQ_EDGE_EN) after request; no backpressure, ack/clear strobes only.
module n1_excpt_ctrl #(
  parameter int IRQ_CNT  = 16,
  parameter int TC_WIDTH = 16
) (
  input logic             clk_i,
  input logic             async_rst_i,
  n1_excpt_ctrl_if.slave  bus
);
  localparam int VEC_W = (IRQ_CNT > 1) ? $clog2(IRQ_CNT) : 1;

  localparam logic [TC_WIDTH-1:0] TC_BUSERR = TC_WIDTH'(-9);
  localparam logic [TC_WIDTH-1:0] TC_RSOF   = TC_WIDTH'(-5);
  localparam logic [TC_WIDTH-1:0] TC_RSUF   = TC_WIDTH'(-6);
  localparam logic [TC_WIDTH-1:0] TC_PSOF   = TC_WIDTH'(-3);
  localparam logic [TC_WIDTH-1:0] TC_PSUF   = TC_WIDTH'(-4);
  localparam logic [TC_WIDTH-1:0] TC_IRQ_BASE = TC_WIDTH'(256);

  typedef enum logic [1:0] {DIS = 2'b00, IDLE = 2'b01, PEND = 2'b10} state_t;

  state_t              state_q, state_d;
  logic [TC_WIDTH-1:0] tc_q, tc_d, src_tc, irq_tc;
  logic                any_src;
  logic [IRQ_CNT-1:0]  irq_r, mask_q, pend, req_m;
  logic                irq_en_q, sel_vld, irq_vld;
  logic [VEC_W-1:0]    sel_idx;

  assign any_src = bus.fc2excpt_buserr_i | bus.sagu2excpt_rsof_i | bus.prs2excpt_rsuf_i
                 | bus.sagu2excpt_psof_i | bus.prs2excpt_psuf_i;

  always_comb begin
    src_tc = '0;
    if (bus.fc2excpt_buserr_i)      src_tc = TC_BUSERR;
    else if (bus.sagu2excpt_rsof_i) src_tc = TC_RSOF;
    else if (bus.prs2excpt_rsuf_i)  src_tc = TC_RSUF;
    else if (bus.sagu2excpt_psof_i) src_tc = TC_PSOF;
    else if (bus.prs2excpt_psuf_i)  src_tc = TC_PSUF;
  end

  // Sources are only looked at in IDLE, so anything raised in DIS or PEND is simply dropped.
  always_comb begin
    state_d = state_q;
    tc_d    = tc_q;
    case (state_q)
      DIS:  if (bus.ir2excpt_excpt_en_i && !bus.ir2excpt_excpt_dis_i) state_d = IDLE;
      IDLE: begin
        if (bus.ir2excpt_excpt_dis_i) begin
          state_d = DIS;
        end else if (any_src) begin
          state_d = PEND;
          tc_d    = src_tc;
        end
      end
      PEND: begin
        if (bus.ir2excpt_excpt_dis_i || bus.fc2excpt_excpt_clr_i) begin
          state_d = DIS;
          tc_d    = '0;
        end
      end
      default: begin
        state_d = DIS;
        tc_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge async_rst_i) begin
    if (!async_rst_i) begin
      state_q  <= DIS;
      tc_q     <= '0;
      irq_r    <= '0;
      mask_q   <= '1;
      irq_en_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tc_q    <= tc_d;
      irq_r   <= bus.irq_req_i;
      if (bus.ir2excpt_irq_mask_we_i) mask_q <= bus.ir2excpt_irq_mask_i;
      if (bus.ir2excpt_irq_dis_i || bus.fc2excpt_irq_ack_i) irq_en_q <= 1'b0;
      else if (bus.ir2excpt_irq_en_i)                       irq_en_q <= 1'b1;
    end
  end

`ifdef N1_EXCPT_IRQ_EDGE_EN
  logic [IRQ_CNT-1:0] irq_prev, pend_q, ack_clr;

  assign ack_clr = (bus.fc2excpt_irq_ack_i && irq_vld) ? (IRQ_CNT'(1) << sel_idx) : '0;

  // The rising-edge term is ORed after the ack clear so a fresh edge in the ack cycle survives.
  always_ff @(posedge clk_i or negedge async_rst_i) begin
    if (!async_rst_i) begin
      irq_prev <= '0;
      pend_q   <= '0;
    end else begin
      irq_prev <= irq_r;
      pend_q   <= (pend_q & ~ack_clr) | (irq_r & ~irq_prev);
    end
  end

  assign pend = pend_q;
`else
  assign pend = irq_r;
`endif

  assign req_m = pend & mask_q;

  always_comb begin
    sel_vld = 1'b0;
    sel_idx = '0;
    for (int i = IRQ_CNT - 1; i >= 0; i--) begin
      if (req_m[i]) begin
        sel_vld = 1'b1;
        sel_idx = VEC_W'(i);
      end
    end
  end

  assign irq_vld = irq_en_q && sel_vld && (state_q != PEND);
  assign irq_tc  = '0 - (TC_IRQ_BASE + TC_WIDTH'(sel_idx));

  assign bus.excpt2fc_excpt_o   = (state_q == PEND);
  assign bus.excpt2fc_irq_o     = irq_vld;
  assign bus.excpt2fc_irq_vec_o = sel_idx;
  assign bus.excpt2prs_tc_o     = (state_q == PEND) ? tc_q : (irq_vld ? irq_tc : '0);
  assign bus.prb_excpt_o        = state_q;
  assign bus.prb_excpt_en_o     = (state_q != DIS);
  assign bus.prb_irq_en_o       = irq_en_q;
  assign bus.prb_irq_pend_o     = pend;
endmodule
